// File: rtl/switch_bounce_gen.sv
// Emulates a mechanical switch: each requested level change is delivered as an
// odd burst of toggles on sw, followed by a stable settle window and a done pulse.
module switch_bounce_gen #(
  parameter int          TICK_M       = 1_000_000,
  parameter int          MAX_BOUNCE   = 7,
  parameter int          SETTLE_TICKS = 4,
  parameter int          RANDOM       = 1,
  parameter logic [15:0] SEED         = 16'hACE1
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic level,
  output logic sw,
  output logic busy,
  output logic done
);

  // state  | meaning
  // IDLE   | waiting for start; sw stable at last requested level
  // BOUNCE | toggle burst in progress, tick_cnt counts down the current interval
  // SETTLE | final level reached, holding sw for SETTLE_TICKS ticks
  typedef enum logic [1:0] {IDLE, BOUNCE, SETTLE} state_t;

  localparam int CYC_W    = $clog2(TICK_M);
  localparam int TICK_MAX = (SETTLE_TICKS > 4) ? SETTLE_TICKS : 4;
  localparam int TCK_W    = $clog2(TICK_MAX);

  localparam logic [CYC_W-1:0] CYC_LOAD    = CYC_W'(TICK_M - 1);
  localparam logic [TCK_W-1:0] SETTLE_LOAD = TCK_W'(SETTLE_TICKS - 1);
  localparam logic [2:0]       MB          = 3'(MAX_BOUNCE);
  localparam logic [15:0]      LFSR_TAPS   = 16'hB400;

  state_t             state, state_nxt;
  logic               sw_nxt, busy_nxt, done_nxt;
  logic [15:0]        lfsr, lfsr_nxt;
  logic [CYC_W-1:0]   cyc_cnt, cyc_nxt;
  logic [TCK_W-1:0]   tick_cnt, tick_nxt;
  logic [3:0]         tog_cnt, tog_nxt;
  logic [2:0]         n_bounce;
  logic [TCK_W-1:0]   ivl_load;

  // Both draws come from the current LFSR value, i.e. the one present at the toggle edge.
  always_comb begin
    n_bounce = MB;
    ivl_load = '0;
    if (RANDOM != 0) begin
      n_bounce = (lfsr[2:0] > MB) ? MB : lfsr[2:0];
      ivl_load = TCK_W'(lfsr[4:3]);
    end
  end

  always_comb begin
    state_nxt = state;
    sw_nxt    = sw;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    cyc_nxt   = cyc_cnt;
    tick_nxt  = tick_cnt;
    tog_nxt   = tog_cnt;
    lfsr_nxt  = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);

    case (state)
      IDLE: begin
        busy_nxt = 1'b0;
        if (start) begin
          if (level == sw) begin
            done_nxt = 1'b1;
          end else begin
            sw_nxt   = ~sw;
            busy_nxt = 1'b1;
            cyc_nxt  = CYC_LOAD;
            if (n_bounce == 3'd0) begin
              state_nxt = SETTLE;
              tick_nxt  = SETTLE_LOAD;
              tog_nxt   = 4'd0;
            end else begin
              state_nxt = BOUNCE;
              tick_nxt  = ivl_load;
              tog_nxt   = {n_bounce, 1'b0};
            end
          end
        end
      end

      BOUNCE: begin
        if (cyc_cnt == '0) begin
          cyc_nxt = CYC_LOAD;
          if (tick_cnt == '0) begin
            sw_nxt  = ~sw;
            tog_nxt = (tog_cnt == 4'd0) ? 4'd0 : tog_cnt - 4'd1;
            if (tog_cnt <= 4'd1) begin
              state_nxt = SETTLE;
              tick_nxt  = SETTLE_LOAD;
            end else begin
              tick_nxt = ivl_load;
            end
          end else begin
            tick_nxt = tick_cnt - 1'b1;
          end
        end else begin
          cyc_nxt = cyc_cnt - 1'b1;
        end
      end

      SETTLE: begin
        if (cyc_cnt == '0) begin
          cyc_nxt = CYC_LOAD;
          if (tick_cnt == '0) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
            busy_nxt  = 1'b0;
            cyc_nxt   = '0;
          end else begin
            tick_nxt = tick_cnt - 1'b1;
          end
        end else begin
          cyc_nxt = cyc_cnt - 1'b1;
        end
      end

      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      sw       <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      lfsr     <= SEED;
      cyc_cnt  <= '0;
      tick_cnt <= '0;
      tog_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      sw       <= sw_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      lfsr     <= lfsr_nxt;
      cyc_cnt  <= cyc_nxt;
      tick_cnt <= tick_nxt;
      tog_cnt  <= tog_nxt;
    end
  end

endmodule

// File: tb/tb_switch_bounce_gen.sv
// Bench for switch_bounce_gen: a fixed-pattern instance for directed cases and an
// LFSR-driven instance for a long randomized run, both checked against a timing model.
module tb_switch_bounce_gen;

  localparam int TM_D = 4, MB_D = 3, ST_D = 2;
  localparam int TM_R = 2, MB_R = 5, ST_R = 1;
  localparam logic [15:0] SEED_R = 16'hACE1;

  logic clk = 1'b0;
  logic reset_d, start_d, level_d, sw_d, busy_d, done_d;
  logic reset_r, start_r, level_r, sw_r, busy_r, done_r;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  logic [15:0] m_lfsr, m_used;

  always #5 clk = ~clk;

  switch_bounce_gen #(.TICK_M(TM_D), .MAX_BOUNCE(MB_D), .SETTLE_TICKS(ST_D), .RANDOM(0)) dut_d (
    .clk(clk), .reset(reset_d), .start(start_d), .level(level_d),
    .sw(sw_d), .busy(busy_d), .done(done_d));

  switch_bounce_gen #(.TICK_M(TM_R), .MAX_BOUNCE(MB_R), .SETTLE_TICKS(ST_R), .RANDOM(1),
                      .SEED(SEED_R)) dut_r (
    .clk(clk), .reset(reset_r), .start(start_r), .level(level_r),
    .sw(sw_r), .busy(busy_r), .done(done_r));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Galois shift right; a 1 shifted out flips the tap positions x^16, x^14, x^13, x^11.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic out;
    out = s[0];
    s   = s >> 1;
    if (out) begin
      s[15] = ~s[15];
      s[13] = ~s[13];
      s[12] = ~s[12];
      s[10] = ~s[10];
    end
    return s;
  endfunction

  always @(posedge clk) cyc++;

  // m_used is the register value the random DUT saw at the most recent edge.
  always @(posedge clk or posedge reset_r) begin
    if (reset_r) begin
      m_lfsr = SEED_R;
      m_used = SEED_R;
    end else begin
      m_used = m_lfsr;
      m_lfsr = lfsr_step(m_lfsr);
    end
  end

  function automatic logic get_sw(input bit r);
    return r ? sw_r : sw_d;
  endfunction
  function automatic logic get_busy(input bit r);
    return r ? busy_r : busy_d;
  endfunction
  function automatic logic get_done(input bit r);
    return r ? done_r : done_d;
  endfunction

  task automatic set_in(input bit r, input logic s, input logic l);
    if (r) begin
      start_r = s;
      level_r = l;
    end else begin
      start_d = s;
      level_d = l;
    end
  endtask

  // One requested transition. pre_driven: start was already set by a chained call.
  // chain: leave start high with the opposite level in the done cycle.
  task automatic transition(input bit r, input logic lvl, input bit noise,
                            input bit chain, input bit pre_driven);
    logic sw0, prev, cur, d;
    int exp_tog, exp_n, gap, settle, tcount, last_t, v;
    bit fin;
    sw0 = get_sw(r);
    if (!pre_driven) set_in(r, 1'b1, lvl);
    @(negedge clk);
    set_in(r, 1'b0, lvl);
    if (lvl == sw0) begin
      chk("same_level_done", get_done(r), 1'b1);
      chk("same_level_sw", get_sw(r), sw0);
      chk("same_level_busy", get_busy(r), 1'b0);
      @(negedge clk);
      chk("same_level_done_once", get_done(r), 1'b0);
      chk("same_level_sw_hold", get_sw(r), sw0);
      return;
    end
    chk("first_toggle", get_sw(r), lvl);
    chk("busy_rise", get_busy(r), 1'b1);
    if (r) begin
      v      = int'(m_used[2:0]);
      exp_n  = (v > MB_R) ? MB_R : v;
      gap    = (1 + int'(m_used[4:3])) * TM_R;
      settle = ST_R * TM_R;
    end else begin
      exp_n  = MB_D;
      gap    = TM_D;
      settle = ST_D * TM_D;
    end
    exp_tog = 2 * exp_n + 1;
    tcount  = 1;
    last_t  = cyc;
    prev    = get_sw(r);
    fin     = 0;
    for (int k = 0; k < 400 && !fin; k++) begin
      @(negedge clk);
      cur = get_sw(r);
      d   = get_done(r);
      if (cur !== prev) begin
        tcount++;
        chk("toggle_spacing", cyc - last_t, gap);
        gap    = r ? (1 + int'(m_used[4:3])) * TM_R : TM_D;
        last_t = cyc;
        prev   = cur;
      end
      if (d === 1'b1) begin
        fin = 1;
        chk("settle_time", cyc - last_t, settle);
      end
      chk("busy_track", get_busy(r), fin ? 1'b0 : 1'b1);
      if (!fin) set_in(r, noise && ($urandom_range(0, 2) == 0), 1'($urandom));
    end
    chk("done_seen", fin, 1'b1);
    chk("toggle_count", tcount, exp_tog);
    chk("toggle_odd", tcount % 2, 1);
    chk("toggle_max", tcount <= 15, 1'b1);
    chk("final_level", get_sw(r), lvl);
    if (chain) begin
      set_in(r, 1'b1, ~lvl);
    end else begin
      set_in(r, 1'b0, lvl);
      @(negedge clk);
      chk("done_single", get_done(r), 1'b0);
      chk("idle_sw_stable", get_sw(r), lvl);
    end
  endtask

  initial begin
    int tg;
    reset_d = 1'b1; reset_r = 1'b1;
    start_d = 1'b0; level_d = 1'b0;
    start_r = 1'b0; level_r = 1'b0;
    #1;
    chk("rst_sw_d", sw_d, 1'b0);
    chk("rst_busy_d", busy_d, 1'b0);
    chk("rst_done_d", done_d, 1'b0);
    chk("rst_sw_r", sw_r, 1'b0);
    chk("rst_busy_r", busy_r, 1'b0);
    repeat (2) @(negedge clk);
    reset_d = 1'b0; reset_r = 1'b0;

    // Basic rise, then same-level request, then fall with ignored start pulses.
    transition(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    transition(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    transition(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Back-to-back: start held through the done cycle.
    transition(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    transition(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Abort mid-burst.
    set_in(1'b0, 1'b1, 1'b1);
    @(negedge clk);
    set_in(1'b0, 1'b0, 1'b1);
    tg = 1;
    for (int k = 0; k < 100 && tg < 3; k++) begin
      logic p;
      p = sw_d;
      @(negedge clk);
      if (sw_d !== p) tg++;
    end
    chk("abort_reached_3", tg, 3);
    #2 reset_d = 1'b1;
    #1;
    chk("abort_sw", sw_d, 1'b0);
    chk("abort_busy", busy_d, 1'b0);
    chk("abort_done", done_d, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("abort_no_done", done_d, 1'b0);
    end
    reset_d = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("post_abort_quiet", done_d | busy_d | sw_d, 1'b0);
    end
    transition(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Randomized run on the LFSR-driven instance.
    for (int i = 0; i < 1000; i++) begin
      transition(1'b1, 1'($urandom), 1'($urandom), 1'b0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
